msrv32_store_buffer_unit: RTL

//  Parametrised successor to the single-entry store unit.
//  - Forms byte/half/word write data and lane mask from funct3, address and rs2.
//  - Queues stores in a DEPTH-entry FIFO and drains them to the data-memory (AHB-lite style) port.
//  - Flags misaligned and illegal stores.
//  - Reports load-after-store hazards against pending entries.
//  - Sits between the execute stage (iadder/rs2) and the data-memory interface.

---
 rtl/msrv32_pkg.sv | 29 ++
 rtl/msrv32_store_format.sv | 54 +++++
 rtl/msrv32_store_buffer_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Purpose : Shared definitions for the store buffer slice: store funct3
//           encodings, AHB-lite transfer types, the queued-entry layout and
//           the drain FSM state type.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package msrv32_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Only the word address is kept: the low two bits are folded into the mask.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_BUSY
  } sb_state_e;

endpackage

// File: rtl/msrv32_store_format.sv
// ---------------------------------------------------------------------------
// msrv32_store_format
// Purpose : Combinational store formatter. Replicates the source data into
//           every lane it may land on and produces the byte-lane mask, plus
//           misaligned / illegal flags for the requested access size.
// Ports   : i_funct3       in  3   store size encoding
//           i_addrLsb      in  2   low bits of the effective address
//           i_rs2          in  32  store source data
//           o_data         out 32  lane-replicated write data
//           o_mask         out 4   byte-lane write mask
//           o_misaligned   out 1   legal size but address not naturally aligned
//           o_illegal      out 1   funct3 is not a store encoding
// ---------------------------------------------------------------------------
module msrv32_store_format
  import msrv32_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addrLsb,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_data,
  output logic [3:0]  o_mask,
  output logic        o_misaligned,
  output logic        o_illegal
);

  // Data is replicated across all lanes so the slave can pick whichever lane
  // the mask enables; misaligned is only meaningful for legal encodings.
  always_comb begin
    o_data       = '0;
    o_mask       = '0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      F3_SB: begin
        o_data = {4{i_rs2[7:0]}};
        o_mask = 4'b0001 << i_addrLsb;
      end
      F3_SH: begin
        o_data       = {2{i_rs2[15:0]}};
        o_mask       = i_addrLsb[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addrLsb[0];
      end
      F3_SW: begin
        o_data       = i_rs2;
        o_mask       = 4'b1111;
        o_misaligned = |i_addrLsb;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_store_buffer_unit.sv
// ---------------------------------------------------------------------------
// msrv32_store_buffer_unit
// Purpose : Queues formatted stores in a DEPTH-entry FIFO and drains them to
//           an AHB-lite style data-memory port, one NONSEQ transfer per entry.
//           Flags misaligned/illegal stores and reports load-after-store
//           hazards against every entry still queued.
// Ports   : ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in  clock, sync active-low reset
//           funct3_in, iadder_in, rs2_in, mem_wr_req_in     store request from execute
//           ahb_ready_in                                    slave ready, pops the head
//           load_addr_in, load_req_in                       load hazard query
//           ms_riscv32_mp_dm{data,addr,wr_mask,wr_req}_out  head entry on the bus
//           ahb_htrans_out                                  IDLE / NONSEQ
//           stall_out                                       FIFO full, no pop this cycle
//           misaligned_store_out, illegal_store_out         1-cycle drop pulses
//           load_hazard_out                                 load hits a queued store
//           sb_empty_out                                    nothing queued, bus idle
// ---------------------------------------------------------------------------
module msrv32_store_buffer_unit
  import msrv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            mem_wr_req_in,
  input  logic            ahb_ready_in,
  input  logic [XLEN-1:0] load_addr_in,
  input  logic            load_req_in,
  output logic [XLEN-1:0] ms_riscv32_mp_dmdata_out,
  output logic [XLEN-1:0] ms_riscv32_mp_dmaddr_out,
  output logic [3:0]      ms_riscv32_mp_dmwr_mask_out,
  output logic            ms_riscv32_mp_dmwr_req_out,
  output logic [1:0]      ahb_htrans_out,
  output logic            stall_out,
  output logic            misaligned_store_out,
  output logic            illegal_store_out,
  output logic            load_hazard_out,
  output logic            sb_empty_out
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  sb_entry_t         r_fifo [DEPTH];
  logic [PTRW-1:0]   r_wrPtr;
  logic [PTRW-1:0]   r_rdPtr;
  logic [CNTW-1:0]   r_count;
  sb_state_e         r_state;
  logic              r_misalignedPulse;
  logic              r_illegalPulse;

  logic [31:0]       w_fmtData;
  logic [3:0]        w_fmtMask;
  logic              w_fmtMisaligned;
  logic              w_fmtIllegal;
  logic              w_busy;
  logic              w_pop;
  logic              w_reqValid;
  logic              w_push;
  logic [CNTW-1:0]   w_countNext;
  sb_entry_t         w_head;
  sb_entry_t         w_newEntry;
  logic [XLEN-1:0]   w_loadWordAddr;
  logic              w_hazardAny;

  msrv32_store_format u_format (
    .i_funct3     (funct3_in),
    .i_addrLsb    (iadder_in[1:0]),
    .i_rs2        (rs2_in),
    .o_data       (w_fmtData),
    .o_mask       (w_fmtMask),
    .o_misaligned (w_fmtMisaligned),
    .o_illegal    (w_fmtIllegal)
  );

  // A pop only happens while a transfer is actually on the bus, so an empty
  // buffer never bypasses a new store straight to the slave.
  assign w_busy     = (r_state == SB_BUSY);
  assign w_pop      = w_busy & ahb_ready_in;
  assign stall_out  = (r_count == CNTW'(DEPTH)) & ~w_pop;
  assign w_reqValid = mem_wr_req_in & ~stall_out;
  assign w_push     = w_reqValid & ~w_fmtIllegal & ~w_fmtMisaligned;

  assign w_newEntry = '{addr: iadder_in[31:2], data: w_fmtData, mask: w_fmtMask};
  assign w_head     = r_fifo[r_rdPtr];

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + CNTW'(1);
      2'b01:   w_countNext = r_count - CNTW'(1);
      default: w_countNext = r_count;
    endcase
  end

  // Entry storage carries no reset: validity comes purely from the pointers
  // and count, which are cleared on reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= w_newEntry;
    end
  end

  // Pointer/count bookkeeping, drain FSM and the one-cycle drop pulses.
  // The FSM leaves BUSY only when the pop empties the buffer with no
  // replacement push in the same cycle.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_wrPtr           <= '0;
      r_rdPtr           <= '0;
      r_count           <= '0;
      r_state           <= SB_IDLE;
      r_misalignedPulse <= 1'b0;
      r_illegalPulse    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      r_count           <= w_countNext;
      r_misalignedPulse <= w_reqValid & w_fmtMisaligned;
      r_illegalPulse    <= w_reqValid & w_fmtIllegal;
      case (r_state)
        SB_IDLE: begin
          if (w_push) begin
            r_state <= SB_BUSY;
          end
        end
        SB_BUSY: begin
          if (w_pop && (w_countNext == '0)) begin
            r_state <= SB_IDLE;
          end
        end
        default: r_state <= SB_IDLE;
      endcase
    end
  end

  // Bus outputs follow the registered state; while IDLE everything reads 0
  // so stale storage never leaks onto the port.
  assign ms_riscv32_mp_dmdata_out    = w_busy ? w_head.data : '0;
  assign ms_riscv32_mp_dmaddr_out    = w_busy ? {w_head.addr, 2'b00} : '0;
  assign ms_riscv32_mp_dmwr_mask_out = w_busy ? w_head.mask : 4'b0000;
  assign ms_riscv32_mp_dmwr_req_out  = w_busy;
  assign ahb_htrans_out              = w_busy ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign misaligned_store_out        = r_misalignedPulse;
  assign illegal_store_out           = r_illegalPulse;
  assign sb_empty_out                = (r_count == '0) & ~w_busy;

  // Hazard compare at word granularity against every occupied slot, the head
  // included. A slot is occupied when its distance from the read pointer
  // (modulo DEPTH) is below the current count.
  assign w_loadWordAddr = load_addr_in & ~XLEN'(3);

  always_comb begin
    logic [PTRW-1:0] offset;
    w_hazardAny = 1'b0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTRW'(i) - r_rdPtr;
      if (({1'b0, offset} < r_count) &&
          ({r_fifo[i].addr, 2'b00} == w_loadWordAddr)) begin
        w_hazardAny = 1'b1;
      end
    end
  end

  assign load_hazard_out = load_req_in & w_hazardAny;

endmodule
